gpio_spi_master: RTL

SPI initiator that drives the 16-bit command frames consumed by gpio_expander (the SPI responder) from a host-side valid/ready command interface. It serialises write/read commands MSB-first in SPI mode 0 (idle sclk low, mosi changes on falling edge, miso sampled on rising edge). It returns the full captured miso frame plus the 8-bit read data. It sits between a local controller (CPU bridge or sequencer) and the expander pins.

---
 rtl/gpio_spi_pkg.sv | 53 +++++
 rtl/gpio_spi_master_clkgen.sv | 44 ++++
 rtl/gpio_spi_master.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/gpio_spi_pkg.sv
// Shared definitions for the gpio SPI link: frame field layout, FSM encoding
// and default widths, used by both the initiator and the expander responder.
package gpio_spi_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_PDATA_WIDTH = 8;
  localparam int DEF_PADDR_WIDTH = 3;
  localparam int SEL_WIDTH       = 2;
  localparam int BIT_CNT_W       = 5;

  localparam int WR_BIT   = 15;
  localparam int SEL_MSB  = 14;
  localparam int SEL_LSB  = 13;
  localparam int ADDR_MSB = 12;
  localparam int ADDR_LSB = 10;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LAG   = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Read frames carry a zero payload so the responder never sees stale data.
  function automatic logic [DEF_DATA_WIDTH-1:0] build_frame(
    input logic                       write,
    input logic [SEL_WIDTH-1:0]       sel,
    input logic [DEF_PADDR_WIDTH-1:0] addr,
    input logic [DEF_PDATA_WIDTH-1:0] wdata
  );
    logic [DEF_DATA_WIDTH-1:0] f;
    f                    = '0;
    f[WR_BIT]            = write;
    f[SEL_MSB:SEL_LSB]   = sel;
    f[ADDR_MSB:ADDR_LSB] = addr;
    if (write) begin
      f[DATA_MSB:DATA_LSB] = wdata;
    end else begin
      f[DATA_MSB:DATA_LSB] = '0;
    end
    return f;
  endfunction

endpackage

// File: rtl/gpio_spi_master_clkgen.sv
// sclk generator: divides clk while enabled and flags the clk edge on which
// sclk rises or falls so the FSM can shift in lock-step.
module gpio_spi_clkgen
  import gpio_spi_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;

  logic [DIV_W-1:0] div_cnt_r;
  logic             sclk_r;
  logic             toggle_s;

  assign toggle_s = en & (div_cnt_r == DIV_W'(CLK_DIV - 1));
  assign rise     = toggle_s & ~sclk_r;
  assign fall     = toggle_s & sclk_r;
  assign sclk     = sclk_r;

  // Divider and sclk register; disabling parks sclk low with a cleared count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt_r <= '0;
      sclk_r    <= 1'b0;
    end else if (!en) begin
      div_cnt_r <= '0;
      sclk_r    <= 1'b0;
    end else if (toggle_s) begin
      div_cnt_r <= '0;
      sclk_r    <= ~sclk_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
      sclk_r    <= sclk_r;
    end
  end

endmodule

// File: rtl/gpio_spi_master.sv
// SPI mode-0 initiator: turns one host command into a 16-bit frame towards
// gpio_expander and returns the captured miso frame.
module gpio_spi_master
  import gpio_spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int PDATA_WIDTH = DEF_PDATA_WIDTH,
  parameter int PADDR_WIDTH = DEF_PADDR_WIDTH,
  parameter int CLK_DIV     = 1,
  parameter int SS_LEAD     = 1,
  parameter int SS_LAG      = 2,
  parameter int SS_GAP      = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [SEL_WIDTH-1:0]   cmd_sel,
  input  logic [PADDR_WIDTH-1:0] cmd_addr,
  input  logic [PDATA_WIDTH-1:0] cmd_wdata,
  output logic                   rsp_valid,
  output logic [DATA_WIDTH-1:0]  rsp_frame,
  output logic [PDATA_WIDTH-1:0] rsp_data,
  output logic                   busy,
  output logic                   sclk,
  output logic                   mosi,
  input  logic                   miso,
  output logic                   ss
);

  localparam int PH_MAX = max3(SS_LEAD, SS_LAG, SS_GAP);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  spi_state_e             state_r;
  spi_state_e             next_state_s;
  logic [PH_W-1:0]        ph_cnt_r;
  logic [BIT_CNT_W-1:0]   bit_cnt_r;
  logic [DATA_WIDTH-1:0]  tx_r;
  logic [DATA_WIDTH-1:0]  rx_r;
  logic [DATA_WIDTH-1:0]  rsp_frame_r;
  logic [DATA_WIDTH-1:0]  frame_s;
  logic                   rsp_valid_r;
  logic                   ss_r;
  logic                   cmd_ready_r;
  logic                   busy_r;
  logic                   accept_s;
  logic                   ph_done_s;
  logic                   last_bit_s;
  logic                   clk_en_s;
  logic                   rise_s;
  logic                   fall_s;

  assign accept_s   = cmd_valid & cmd_ready_r;
  assign frame_s    = build_frame(cmd_write, cmd_sel, cmd_addr, cmd_wdata);
  assign last_bit_s = (bit_cnt_r == BIT_CNT_W'(DATA_WIDTH - 1));
  assign clk_en_s   = (state_r == ST_SHIFT);

  gpio_spi_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk   (clk),
    .resetn(resetn),
    .en    (clk_en_s),
    .rise  (rise_s),
    .fall  (fall_s),
    .sclk  (sclk)
  );

  // Next-state decode; LEAD/LAG/GAP dwell on ph_cnt_r, SHIFT ends on the 16th fall.
  always_comb begin
    next_state_s = state_r;
    ph_done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = ST_LEAD;
        else          next_state_s = ST_IDLE;
      end
      ST_LEAD: begin
        ph_done_s = (ph_cnt_r == PH_W'(SS_LEAD - 1));
        if (ph_done_s) next_state_s = ST_SHIFT;
        else           next_state_s = ST_LEAD;
      end
      ST_SHIFT: begin
        if (fall_s && last_bit_s) next_state_s = ST_LAG;
        else                      next_state_s = ST_SHIFT;
      end
      ST_LAG: begin
        ph_done_s = (ph_cnt_r == PH_W'(SS_LAG - 1));
        if (ph_done_s) next_state_s = ST_GAP;
        else           next_state_s = ST_LAG;
      end
      ST_GAP: begin
        ph_done_s = (ph_cnt_r == PH_W'(SS_GAP - 1));
        if (ph_done_s) next_state_s = ST_IDLE;
        else           next_state_s = ST_GAP;
      end
      default: begin
        next_state_s = ST_IDLE;
        ph_done_s    = 1'b0;
      end
    endcase
  end

  // State register and dwell counter for the timed ss phases.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      ph_cnt_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (next_state_s != state_r) begin
        ph_cnt_r <= '0;
      end else if (state_r == ST_LEAD || state_r == ST_LAG || state_r == ST_GAP) begin
        ph_cnt_r <= ph_cnt_r + PH_W'(1);
      end else begin
        ph_cnt_r <= '0;
      end
    end
  end

  // Datapath: frame load, miso capture on rise, mosi advance on fall, response latch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_r        <= '0;
      rx_r        <= '0;
      rsp_frame_r <= '0;
      rsp_valid_r <= 1'b0;
      bit_cnt_r   <= '0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            tx_r      <= frame_s;
            rx_r      <= '0;
            bit_cnt_r <= '0;
          end
        end
        ST_SHIFT: begin
          if (rise_s) rx_r <= {rx_r[DATA_WIDTH-2:0], miso};
          if (fall_s) begin
            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
            // mosi stays on the last bit through LAG
            if (!last_bit_s) tx_r <= {tx_r[DATA_WIDTH-2:0], 1'b0};
          end
        end
        ST_LAG: begin
          if (ph_done_s) begin
            rsp_frame_r <= rx_r;
            rsp_valid_r <= 1'b1;
            tx_r        <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered handshake and select outputs, decoded from the upcoming state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ss_r        <= 1'b1;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      ss_r        <= ~((next_state_s == ST_LEAD) || (next_state_s == ST_SHIFT) ||
                       (next_state_s == ST_LAG));
      cmd_ready_r <= (next_state_s == ST_IDLE);
      busy_r      <= (next_state_s != ST_IDLE);
    end
  end

  assign mosi      = tx_r[DATA_WIDTH-1];
  assign ss        = ss_r;
  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_frame = rsp_frame_r;
  assign rsp_data  = rsp_frame_r[DATA_MSB:DATA_LSB];

endmodule
